dual_rail_count_source: RTL and testbench
=========================================

Name: dual_rail_count_source

Overview:
- Clocked, 4-bit binary counter that emits each count value as a dual-rail (THDR) code word on A..D, with A as MSB.
- Feeds the dual-rail binary-to-Gray encoder stage directly. Its A_t..D_f outputs connect one-to-one to the encoder inputs.
- Uses a return-to-zero protocol: every valid code word is followed by a spacer (all rails 0).
- Advances only after the downstream completion detector acknowledges data and then spacer.

Parameters:
- WIDTH, 4, counter width. Fixed at 4 for the encoder pairing; bit WIDTH-1 drives A, bit 0 drives D.
- TIMEOUT_CYCLES, 16, watchdog limit in clk cycles. Used only with ACK_TIMEOUT_EN.

Ports:
- clk  input  1  single system clock; all state on the rising edge.
- rst  input  1  reset. Synchronous, active-high.
- en  input  1  permit issuing a new code word.
- load  input  1  load load_val into the counter. Honoured only in S_NULL.
- load_val  input  WIDTH  value loaded by load.
- ack_in  input  1  downstream completion. 1 = downstream outputs all valid; 0 = all spacer. Synchronous to clk.
- A_t, A_f, B_t, B_f, C_t, C_f, D_t, D_f  output  1 each  registered dual-rail code word.
- count_o  output  WIDTH  registered binary counter value (debug).
- busy  output  1  1 while in S_DATA.
- wrap  output  1  one-cycle pulse when the count advances from 15 to 0.
- err  output  1  sticky watchdog flag (see Optional Feature).

Behaviour:
- Reset (rst=1 at clk edge):
  - state=S_NULL, count=0, all eight rails=0, busy=0, wrap=0, err=0.
  - Reset applies from any state, including mid-handshake. The next cycle shows a spacer.
- Invariant: X_t & X_f is never 1 for any rail pair. All rails are driven from registers; there are no combinational paths from inputs to rails.
- S_NULL: rails all 0.
  - If load=1: count<=load_val, stay in S_NULL. load has priority over en.
  - Else if en=1 and ack_in=0: next state S_DATA. On the same edge X_t<=count[i], X_f<=~count[i], busy<=1.
  - If ack_in=1 (downstream still holds data), stay in S_NULL regardless of en.
- S_DATA: rails hold the code word stable; load is ignored.
  - When ack_in=1 is sampled: next state S_NULL, rails<=0, busy<=0, count<=count+1 mod 2^WIDTH.
  - On the 15->0 transition, wrap=1 for exactly that one cycle.
  - en deassertion in S_DATA does not abort the word; the handshake completes.
- Latency:
  - First code word appears 1 cycle after en=1 & ack_in=0 is sampled in S_NULL.
  - With a combinational downstream completion detector, sustained throughput is 1 word per 2 cycles (data, spacer).
- count_o always reflects the registered count. During S_DATA it equals the value on the rails.
- Simultaneous events: rst beats everything, then load, then en.

Optional Feature:
- Macro: ACK_TIMEOUT_EN.
- Enabled:
  - A watchdog counter clears on every state change.
  - It increments each cycle while in S_DATA with ack_in=0, or in S_NULL with ack_in=1.
  - On reaching TIMEOUT_CYCLES, err<=1. err is sticky until rst; the FSM keeps waiting.
- Disabled: no watchdog logic; err is tied to 0.

Test Plan:
- Reset, en=1, ack model = completion of encoder outputs -> rails show 0000,spacer,0001,spacer,...,1111,spacer,0000. wrap pulses once on the 15->0 advance; 2 cycles per word.
- In S_DATA with count=5, hold ack_in=0 for 5 cycles -> A_f,B_t,C_f,D_t held at 1 every cycle, count_o=5, busy=1. Release ack_in -> spacer next cycle, count_o=6.
- After a spacer, hold ack_in=1 with en=1 -> rails stay 0, no advance until ack_in=0.
- In S_NULL assert load=1, load_val=4'b1010, en=1 -> no data that cycle. Next word has A_t,B_f,C_t,D_f=1, and the encoder outputs Gray 1111.
- Assert rst during S_DATA with count=9 -> next cycle all rails 0, count_o=0, busy=0, wrap=0, err=0.
- With ACK_TIMEOUT_EN and TIMEOUT_CYCLES=16, hold ack_in=0 in S_DATA for 16 cycles -> err=1 and stays 1 after ack resumes, until rst. Without the macro, err=0 throughout.

Source files
------------

// File: rtl/dual_rail_count_source_if.sv
// Handshake and code-word bundle between the dual-rail count source and its environment.
// master: the count source side. slave: the control and completion-detector side.
interface dual_rail_count_source_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             ack_in;

    logic             A_t;
    logic             A_f;
    logic             B_t;
    logic             B_f;
    logic             C_t;
    logic             C_f;
    logic             D_t;
    logic             D_f;

    logic [WIDTH-1:0] count_o;
    logic             busy;
    logic             wrap;
    logic             err;

    modport master (
        input  en, load, load_val, ack_in,
        output A_t, A_f, B_t, B_f, C_t, C_f, D_t, D_f,
        output count_o, busy, wrap, err
    );

    modport slave (
        output en, load, load_val, ack_in,
        input  A_t, A_f, B_t, B_f, C_t, C_f, D_t, D_f,
        input  count_o, busy, wrap, err
    );
endinterface

// File: rtl/dual_rail_count_source.sv
// Purpose: 4-bit counter emitting each value as a return-to-zero dual-rail word (A = MSB).
// Latency: word appears 1 cycle after en & !ack_in in S_NULL; one word per 2 cycles with a combinational ack.
// Backpressure: holds data until ack_in=1, holds spacer until ack_in=0. Optional watchdog: ACK_TIMEOUT_EN.
module dual_rail_count_source #(
    parameter int WIDTH          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    dual_rail_count_source_if.master   bus
);
    localparam logic [0:0] S_NULL = 1'b0;
    localparam logic [0:0] S_DATA = 1'b1;

    if (WIDTH != 4) begin : g_width_chk
        $error("dual_rail_count_source: WIDTH must be 4 to pair with the Gray encoder");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
        $error("dual_rail_count_source: TIMEOUT_CYCLES must be at least 1");
    end

    logic [0:0]       state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] rail_t;
    logic [WIDTH-1:0] rail_f;
    logic             busy_q;
    logic             wrap_q;
    logic             issue;
    logic             retire;

    // load outranks en; a lingering ack from downstream blocks a new word
    assign issue  = (state == S_NULL) && !bus.load && bus.en && !bus.ack_in;
    assign retire = (state == S_DATA) && bus.ack_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_NULL;
            count  <= '0;
            rail_t <= '0;
            rail_f <= '0;
            busy_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if ((state == S_NULL) && bus.load) begin
                count <= bus.load_val;
            end
            if (issue) begin
                state  <= S_DATA;
                rail_t <= count;
                rail_f <= ~count;
                busy_q <= 1'b1;
            end
            if (retire) begin
                state  <= S_NULL;
                rail_t <= '0;
                rail_f <= '0;
                busy_q <= 1'b0;
                count  <= count + 1'b1;
                wrap_q <= &count;
            end
        end
    end

    assign bus.A_t     = rail_t[WIDTH-1];
    assign bus.A_f     = rail_f[WIDTH-1];
    assign bus.B_t     = rail_t[WIDTH-2];
    assign bus.B_f     = rail_f[WIDTH-2];
    assign bus.C_t     = rail_t[WIDTH-3];
    assign bus.C_f     = rail_f[WIDTH-3];
    assign bus.D_t     = rail_t[WIDTH-4];
    assign bus.D_f     = rail_f[WIDTH-4];
    assign bus.count_o = count;
    assign bus.busy    = busy_q;
    assign bus.wrap    = wrap_q;

`ifdef ACK_TIMEOUT_EN
    localparam int               WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_TOP = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt;
    logic            waiting;
    logic            err_q;

    // stalled means data not yet acknowledged, or spacer not yet acknowledged
    assign waiting = (state == S_DATA) ? !bus.ack_in : bus.ack_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else if (issue || retire) begin
            wd_cnt <= '0;
        end else if (waiting) begin
            if (wd_cnt != WD_TOP) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_cnt == WD_TOP - 1'b1) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_dual_rail_count_source.sv
// Directed scenarios plus randomized traffic checked against a behavioural model of the counter.
module tb_dual_rail_count_source;
    localparam int W       = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    logic auto_ack;
    logic ack_drv;
    logic done;

    int n_cmp = 0;
    int n_bad = 0;

    dual_rail_count_source_if #(.WIDTH(W)) bus ();

    dual_rail_count_source #(.WIDTH(W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // downstream completion: 1 when every pair holds a valid rail, 0 when all spacer
    assign done = (bus.A_t | bus.A_f) & (bus.B_t | bus.B_f) & (bus.C_t | bus.C_f) & (bus.D_t | bus.D_f);
    assign bus.ack_in = auto_ack ? done : ack_drv;

    // behavioural reference
    bit m_data;
    int m_count;
    bit m_wrap;
    bit m_err;
    int m_wd;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] obs_rails();
        return {bus.A_t, bus.A_f, bus.B_t, bus.B_f, bus.C_t, bus.C_f, bus.D_t, bus.D_f};
    endfunction

    function automatic logic [7:0] exp_rails();
        logic [7:0] r = '0;
        if (m_data) begin
            for (int i = 0; i < 4; i++) begin
                r[2*i+1] = ((m_count >> i) & 1) == 1;
                r[2*i]   = ((m_count >> i) & 1) == 0;
            end
        end
        return r;
    endfunction

    task automatic model_step(input bit r, input bit e, input bit l, input int lv, input bit a);
        bit was_data;
        was_data = m_data;
        if (r) begin
            m_data = 0; m_count = 0; m_wrap = 0; m_err = 0; m_wd = 0;
            return;
        end
        m_wrap = 0;
        if (!m_data) begin
            if (l) m_count = lv;
            else if (e && !a) m_data = 1;
        end else if (a) begin
            m_data  = 0;
            m_wrap  = (m_count == 15);
            m_count = (m_count + 1) % 16;
        end
`ifdef ACK_TIMEOUT_EN
        if (m_data != was_data) m_wd = 0;
        else if ((was_data && !a) || (!was_data && a)) begin
            m_wd++;
            if (m_wd >= TIMEOUT) m_err = 1;
        end
`else
        if (was_data && m_wd < 0) m_wd = 0;
`endif
    endtask

    task automatic compare_all();
        logic [7:0] o;
        o = obs_rails();
        chk("rails", o, exp_rails());
        chk("pair_excl", {o[7], o[5], o[3], o[1]} & {o[6], o[4], o[2], o[0]}, 0);
        chk("count_o", bus.count_o, m_count);
        chk("busy", bus.busy, m_data);
        chk("wrap", bus.wrap, m_wrap);
        chk("err", bus.err, m_err);
    endtask

    // inputs are already set; sample them as the DUT will, then check the result
    task automatic cycle();
        bit r, e, l, a;
        int lv;
        #1;
        r = rst; e = bus.en; l = bus.load; lv = int'(bus.load_val); a = bus.ack_in;
        @(posedge clk);
        model_step(r, e, l, lv, a);
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit r, input bit e, input bit l, input logic [3:0] lv,
                         input bit aa, input bit ad);
        rst = r; bus.en = e; bus.load = l; bus.load_val = lv; auto_ack = aa; ack_drv = ad;
    endtask

    initial begin
        int words;
        int wraps;
        bit prev_busy;
        logic [3:0] b;
        logic [3:0] g;

        drive(1, 0, 0, 4'h0, 0, 0);
        m_data = 0; m_count = 0; m_wrap = 0; m_err = 0; m_wd = 0;
        @(negedge clk);
        cycle();
        cycle();

        // free run with a combinational completion detector: 17 words in 34 cycles, one wrap
        drive(0, 1, 0, 4'h0, 1, 0);
        words = 0; wraps = 0; prev_busy = 0;
        for (int i = 0; i < 34; i++) begin
            cycle();
            if (bus.busy && !prev_busy) words++;
            if (bus.wrap) wraps++;
            prev_busy = bus.busy;
        end
        chk("run_words", words, 17);
        chk("run_wraps", wraps, 1);

        // hold data word 5 against a stalled ack
        drive(1, 0, 0, 4'h0, 0, 0); cycle();
        drive(0, 1, 1, 4'h5, 0, 0); cycle();
        drive(0, 1, 0, 4'h0, 0, 0); cycle();
        drive(0, 0, 0, 4'h0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("hold5_rails", obs_rails(), 8'b0110_0110);
            chk("hold5_count", bus.count_o, 5);
        end
        drive(0, 1, 0, 4'h0, 0, 1); cycle();
        chk("release_count", bus.count_o, 6);
        chk("release_rails", obs_rails(), 0);

        // spacer stall: ack stays high, en high, no new word
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("ackhi_busy", bus.busy, 0);
        end

        // load beats en; next word is 1010 which Gray-encodes to 1111
        drive(0, 1, 1, 4'hA, 0, 0); cycle();
        chk("load_nodata", bus.busy, 0);
        drive(0, 1, 0, 4'h0, 0, 0); cycle();
        chk("load_rails", obs_rails(), 8'b1001_1001);
        b = {bus.A_t, bus.B_t, bus.C_t, bus.D_t};
        g = b ^ (b >> 1);
        chk("load_gray", g, 4'b1111);

        // reset in the middle of word 9
        drive(0, 0, 0, 4'h0, 0, 1); cycle();
        drive(0, 0, 1, 4'h9, 0, 0); cycle();
        drive(0, 1, 0, 4'h0, 0, 0); cycle();
        chk("pre_rst_count", bus.count_o, 9);
        drive(1, 1, 0, 4'h0, 0, 0); cycle();
        chk("rst_rails", obs_rails(), 0);
        chk("rst_count", bus.count_o, 0);

        // watchdog stall of TIMEOUT cycles in S_DATA, then resume
        drive(0, 1, 0, 4'h0, 0, 0);
        for (int i = 0; i < TIMEOUT + 3; i++) cycle();
        drive(0, 1, 0, 4'h0, 1, 0);
        for (int i = 0; i < 6; i++) cycle();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ((i % 50) == 0) auto_ack = ($urandom_range(0, 1) == 1);
            rst          = ($urandom_range(0, 99) < 2);
            bus.en       = ($urandom_range(0, 3) != 0);
            bus.load     = ($urandom_range(0, 9) == 0);
            bus.load_val = 4'($urandom_range(0, 15));
            ack_drv      = ($urandom_range(0, 2) == 0) ? ~bus.busy : bus.busy;
            if ($urandom_range(0, 9) == 0) ack_drv = ~ack_drv;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
